// File: rtl/conv_scan_ctrl.sv
// -----------------------------------------------------------------------------
// conv_scan_ctrl
//
// Layer-level sequencer for one convolution layer. On an accepted start it
// latches the layer geometry, requests the IFM load once, and then for every
// output-channel group requests a filter load and walks every
// (row, input-channel, column) position, column innermost. During the walk it
// presents the scan position, the first/last position flags and a run strobe
// to the buffer manager and PE datapath.
//
// Ports
//   clk, rstn             clock; asynchronous active-low reset
//   q_start               one-cycle layer start pulse (accepted in IDLE only)
//   q_width, q_height     IFM width / height, latched on start
//   q_channel             tiled input-channel count, latched on start
//   q_outchn_num          number of output-channel groups, latched on start
//   o_busy                high from the cycle after start through the o_done cycle
//   o_done                one-cycle layer-complete pulse
//   o_load_ifm            one-cycle IFM load request
//   i_load_ifm_done       IFM load complete pulse
//   o_load_filter         one-cycle filter load request
//   o_outchn              current output-channel group index
//   i_load_filter_done    filter load complete pulse
//   i_stall               datapath backpressure; freezes the scan
//   c_ctrl_data_run       scan position valid this cycle
//   c_row, c_col, c_chn   current scan position
//   c_is_first_* / c_is_last_*  position flags for row, column and channel
// -----------------------------------------------------------------------------
module conv_scan_ctrl #(
    parameter int W_SIZE    = 10,
    parameter int W_CHANNEL = 10
) (
    input  logic                 clk,
    input  logic                 rstn,

    input  logic                 q_start,
    input  logic [W_SIZE-1:0]    q_width,
    input  logic [W_SIZE-1:0]    q_height,
    input  logic [W_CHANNEL-1:0] q_channel,
    input  logic [W_CHANNEL-1:0] q_outchn_num,
    output logic                 o_busy,
    output logic                 o_done,

    output logic                 o_load_ifm,
    input  logic                 i_load_ifm_done,
    output logic                 o_load_filter,
    output logic [W_CHANNEL-1:0] o_outchn,
    input  logic                 i_load_filter_done,

    input  logic                 i_stall,
    output logic                 c_ctrl_data_run,
    output logic [W_SIZE-1:0]    c_row,
    output logic [W_SIZE-1:0]    c_col,
    output logic [W_CHANNEL-1:0] c_chn,
    output logic                 c_is_first_row,
    output logic                 c_is_last_row,
    output logic                 c_is_first_col,
    output logic                 c_is_last_col,
    output logic                 c_is_first_chn,
    output logic                 c_is_last_chn
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_IFM  = 3'd1,
        S_LOAD_FILT = 3'd2,
        S_RUN       = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                 r_state;

    // Latched layer geometry.
    logic [W_SIZE-1:0]      r_width;
    logic [W_SIZE-1:0]      r_height;
    logic [W_CHANNEL-1:0]   r_channel;
    logic [W_CHANNEL-1:0]   r_outchn_num;

    // Scan position and output-channel group.
    logic [W_SIZE-1:0]      r_row;
    logic [W_SIZE-1:0]      r_col;
    logic [W_CHANNEL-1:0]   r_chn;
    logic [W_CHANNEL-1:0]   r_outchn;

    // Registered control outputs.
    logic                   r_busy;
    logic                   r_done;
    logic                   r_load_ifm;
    logic                   r_load_filter;

    // Last-index values, computed at the width of the dimension itself.
    logic [W_SIZE-1:0]      w_width_m1;
    logic [W_SIZE-1:0]      w_height_m1;
    logic [W_CHANNEL-1:0]   w_channel_m1;
    logic [W_CHANNEL-1:0]   w_outchn_m1;

    logic                   w_last_col;
    logic                   w_last_row;
    logic                   w_last_chn;
    logic                   w_last_grp;
    logic                   w_in_run;
    logic                   w_advance;
    logic                   w_zero_dim;

    assign w_width_m1   = r_width      - W_SIZE'(1);
    assign w_height_m1  = r_height     - W_SIZE'(1);
    assign w_channel_m1 = r_channel    - W_CHANNEL'(1);
    assign w_outchn_m1  = r_outchn_num - W_CHANNEL'(1);

    assign w_last_col   = (r_col    == w_width_m1);
    assign w_last_row   = (r_row    == w_height_m1);
    assign w_last_chn   = (r_chn    == w_channel_m1);
    assign w_last_grp   = (r_outchn == w_outchn_m1);

    assign w_in_run     = (r_state == S_RUN);
    assign w_advance    = w_in_run && !i_stall;

    // A layer with any empty dimension has nothing to load or scan.
    assign w_zero_dim   = (q_width == '0) || (q_height == '0) ||
                          (q_channel == '0) || (q_outchn_num == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_width       <= '0;
            r_height      <= '0;
            r_channel     <= '0;
            r_outchn_num  <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_chn         <= '0;
            r_outchn      <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_load_ifm    <= 1'b0;
            r_load_filter <= 1'b0;
        end else begin
            // Request and completion outputs are single-cycle pulses.
            r_load_ifm    <= 1'b0;
            r_load_filter <= 1'b0;
            r_done        <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (q_start) begin
                        r_width      <= q_width;
                        r_height     <= q_height;
                        r_channel    <= q_channel;
                        r_outchn_num <= q_outchn_num;
                        r_row        <= '0;
                        r_col        <= '0;
                        r_chn        <= '0;
                        r_outchn     <= '0;
                        r_busy       <= 1'b1;
                        if (w_zero_dim) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_LOAD_IFM;
                            r_load_ifm <= 1'b1;
                        end
                    end
                end

                S_LOAD_IFM: begin
                    // The completion is only honoured once the request
                    // cycle has passed, so a done coinciding with the
                    // request itself cannot short-circuit the load.
                    if (i_load_ifm_done && !r_load_ifm) begin
                        r_state       <= S_LOAD_FILT;
                        r_load_filter <= 1'b1;
                    end
                end

                S_LOAD_FILT: begin
                    if (i_load_filter_done && !r_load_filter) begin
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (!i_stall) begin
                        if (w_last_col) begin
                            r_col <= '0;
                            if (w_last_chn) begin
                                r_chn <= '0;
                                if (w_last_row) begin
                                    // End of the scan for this group.
                                    r_row <= '0;
                                    if (!w_last_grp) begin
                                        r_outchn      <= r_outchn + W_CHANNEL'(1);
                                        r_state       <= S_LOAD_FILT;
                                        r_load_filter <= 1'b1;
                                    end else begin
                                        r_state <= S_DONE;
                                        r_done  <= 1'b1;
                                    end
                                end else begin
                                    r_row <= r_row + W_SIZE'(1);
                                end
                            end else begin
                                r_chn <= r_chn + W_CHANNEL'(1);
                            end
                        end else begin
                            r_col <= r_col + W_SIZE'(1);
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_load_ifm      = r_load_ifm;
    assign o_load_filter   = r_load_filter;
    assign o_outchn        = r_outchn;

    assign c_ctrl_data_run = w_advance;
    assign c_row           = r_row;
    assign c_col           = r_col;
    assign c_chn           = r_chn;

    // Flags only carry meaning while scanning; outside RUN they read 0 so
    // the idle/reset interface is all-zero. They are not gated by i_stall,
    // so they hold with the counters during backpressure.
    assign c_is_first_row  = w_in_run && (r_row == '0);
    assign c_is_last_row   = w_in_run && w_last_row;
    assign c_is_first_col  = w_in_run && (r_col == '0);
    assign c_is_last_col   = w_in_run && w_last_col;
    assign c_is_first_chn  = w_in_run && (r_chn == '0);
    assign c_is_last_chn   = w_in_run && w_last_chn;

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv_scan_ctrl
//
// Directed bench for conv_scan_ctrl. A monitor samples every DUT output on the
// falling edge and logs pulses and scan positions with a cycle index; a
// responder answers each load request with a done pulse one cycle later.
// Each test task starts a layer, waits (bounded) for o_done and compares the
// logs against hand-derived timelines.
// -----------------------------------------------------------------------------
module tb_conv_scan_ctrl;

    localparam int WS = 10;
    localparam int WC = 10;

    // Expected (row, chn, col) order for W=H=C=2.
    localparam logic [2:0] SEQ [8] = '{3'b000, 3'b001, 3'b010, 3'b011,
                                       3'b100, 3'b101, 3'b110, 3'b111};

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          q_start = 1'b0;
    logic [WS-1:0] q_width = '0;
    logic [WS-1:0] q_height = '0;
    logic [WC-1:0] q_channel = '0;
    logic [WC-1:0] q_outchn_num = '0;
    logic          i_load_ifm_done = 1'b0;
    logic          i_load_filter_done = 1'b0;
    logic          i_stall = 1'b0;

    logic          o_busy, o_done, o_load_ifm, o_load_filter;
    logic [WC-1:0] o_outchn;
    logic          c_ctrl_data_run;
    logic [WS-1:0] c_row, c_col;
    logic [WC-1:0] c_chn;
    logic          c_is_first_row, c_is_last_row, c_is_first_col;
    logic          c_is_last_col, c_is_first_chn, c_is_last_chn;

    conv_scan_ctrl #(.W_SIZE(WS), .W_CHANNEL(WC)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .q_start            (q_start),
        .q_width            (q_width),
        .q_height           (q_height),
        .q_channel          (q_channel),
        .q_outchn_num       (q_outchn_num),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_load_ifm         (o_load_ifm),
        .i_load_ifm_done    (i_load_ifm_done),
        .o_load_filter      (o_load_filter),
        .o_outchn           (o_outchn),
        .i_load_filter_done (i_load_filter_done),
        .i_stall            (i_stall),
        .c_ctrl_data_run    (c_ctrl_data_run),
        .c_row              (c_row),
        .c_col              (c_col),
        .c_chn              (c_chn),
        .c_is_first_row     (c_is_first_row),
        .c_is_last_row      (c_is_last_row),
        .c_is_first_col     (c_is_first_col),
        .c_is_last_col      (c_is_last_col),
        .c_is_first_chn     (c_is_first_chn),
        .c_is_last_chn      (c_is_last_chn)
    );

    always #5 clk = ~clk;

    // flags = {first_row, last_row, first_chn, last_chn, first_col, last_col}
    typedef struct packed {
        int            cyc;
        logic          run;
        logic [WS-1:0] row;
        logic [WC-1:0] chn;
        logic [WS-1:0] col;
        logic [WC-1:0] outchn;
        logic [5:0]    flags;
    } snap_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    logic  ifm_seen = 1'b0;
    logic  filt_seen = 1'b0;
    logic  spur_ifm = 1'b0;

    snap_t run_q[$];
    snap_t filt_q[$];
    snap_t stall_q[$];
    int    ifm_q[$];
    int    done_q[$];
    int    start_q[$];
    int    busy_q[$];

    function automatic snap_t take_snap();
        snap_t s;
        s.cyc    = cyc;
        s.run    = c_ctrl_data_run;
        s.row    = c_row;
        s.chn    = c_chn;
        s.col    = c_col;
        s.outchn = o_outchn;
        s.flags  = {c_is_first_row, c_is_last_row, c_is_first_chn,
                    c_is_last_chn, c_is_first_col, c_is_last_col};
        return s;
    endfunction

    // Monitor: one sample per cycle, away from the rising edge.
    initial forever begin
        @(negedge clk);
        cyc = cyc + 1;
        ifm_seen  = o_load_ifm;
        filt_seen = o_load_filter;
        if (q_start)         start_q.push_back(cyc);
        if (o_load_ifm)      ifm_q.push_back(cyc);
        if (o_load_filter)   filt_q.push_back(take_snap());
        if (o_done)          done_q.push_back(cyc);
        if (o_busy)          busy_q.push_back(cyc);
        if (c_ctrl_data_run) run_q.push_back(take_snap());
        if (i_stall)         stall_q.push_back(take_snap());
    end

    // Responder: a request seen in cycle k is answered in cycle k+1.
    initial forever begin
        @(posedge clk);
        #2;
        i_load_ifm_done    = ifm_seen | spur_ifm;
        i_load_filter_done = filt_seen;
    end

    task automatic start_layer(input logic [WS-1:0] w, input logic [WS-1:0] h,
                               input logic [WC-1:0] c, input logic [WC-1:0] n);
        @(posedge clk); #1;
        q_width = w; q_height = h; q_channel = c; q_outchn_num = n;
        q_start = 1'b1;
        @(posedge clk); #1;
        q_start = 1'b0;
        // Scramble the geometry; it must have been latched already.
        q_width = WS'(5); q_height = WS'(5); q_channel = WC'(4); q_outchn_num = WC'(2);
    endtask

    task automatic wait_done(input int base, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (done_q.size() > base) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [10:0] ctl;
        repeat (3) @(posedge clk);
        #1;
        ctl = {o_busy, o_done, o_load_ifm, o_load_filter, c_ctrl_data_run,
               c_is_first_row, c_is_last_row, c_is_first_col, c_is_last_col,
               c_is_first_chn, c_is_last_chn};
        n_tests++;
        if (ctl !== 11'd0) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected 0", ctl);
        end
        n_tests++;
        if ({c_row, c_col, c_chn, o_outchn} !== 40'd0) begin
            n_fail++; $display("FAIL reset_cnt: got row=%0d col=%0d chn=%0d outchn=%0d expected 0",
                               c_row, c_col, c_chn, o_outchn);
        end
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({o_busy, o_load_ifm, c_ctrl_data_run} !== 3'b000) begin
            n_fail++; $display("FAIL reset_idle: got busy=%b ifm=%b run=%b expected 0",
                               o_busy, o_load_ifm, c_ctrl_data_run);
        end
        $display("[TB] test_reset done");
    endtask

    // Shared body for the W=H=C=2, N=1 layer checks.
    task automatic check_basic(input string tag, input int rb, input int ib,
                               input int fb, input int db, input int t0,
                               input int done_off);
        int   nrun;
        logic r, c, l;
        nrun = run_q.size() - rb;
        n_tests++;
        if (nrun !== 8) begin
            n_fail++; $display("FAIL %s_run_count: got %0d expected 8", tag, nrun);
        end
        for (int i = 0; i < 8 && i < nrun; i++) begin
            r = SEQ[i][2]; c = SEQ[i][1]; l = SEQ[i][0];
            n_tests++;
            if ({run_q[rb+i].row, run_q[rb+i].chn, run_q[rb+i].col} !==
                {WS'(r), WC'(c), WS'(l)}) begin
                n_fail++; $display("FAIL %s_pos[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d",
                                   tag, i, run_q[rb+i].row, run_q[rb+i].chn, run_q[rb+i].col, r, c, l);
            end
            n_tests++;
            if (run_q[rb+i].flags !== {~r, r, ~c, c, ~l, l}) begin
                n_fail++; $display("FAIL %s_flags[%0d]: got %b expected %b",
                                   tag, i, run_q[rb+i].flags, {~r, r, ~c, c, ~l, l});
            end
        end
        n_tests++;
        if (ifm_q.size() - ib !== 1 || (ifm_q.size() > ib && ifm_q[ib] !== t0 + 1)) begin
            n_fail++; $display("FAIL %s_load_ifm: got count=%0d expected one pulse at start+1",
                               tag, ifm_q.size() - ib);
        end
        n_tests++;
        if (filt_q.size() - fb !== 1 || (filt_q.size() > fb && filt_q[fb].cyc !== t0 + 3)) begin
            n_fail++; $display("FAIL %s_load_filter: got count=%0d expected one pulse at start+3",
                               tag, filt_q.size() - fb);
        end
        n_tests++;
        if (done_q.size() - db !== 1 || (done_q.size() > db && done_q[db] !== t0 + done_off)) begin
            n_fail++; $display("FAIL %s_done: got count=%0d at %0d expected one pulse at %0d",
                               tag, done_q.size() - db,
                               (done_q.size() > db) ? done_q[db] - t0 : -1, done_off);
        end
    endtask

    task automatic test_basic;
        int rb, ib, fb, db, sb, bb, t0; bit ok;
        rb = run_q.size(); ib = ifm_q.size(); fb = filt_q.size();
        db = done_q.size(); sb = start_q.size(); bb = busy_q.size();
        start_layer(WS'(2), WS'(2), WC'(2), WC'(1));
        wait_done(db, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout: got no o_done expected one"); end
        t0 = (start_q.size() > sb) ? start_q[sb] : 0;
        check_basic("basic", rb, ib, fb, db, t0, 13);
        for (int i = 0; i < 8 && rb + i < run_q.size(); i++) begin
            n_tests++;
            if (run_q[rb+i].cyc !== t0 + 5 + i) begin
                n_fail++; $display("FAIL basic_run_cycle[%0d]: got %0d expected %0d",
                                   i, run_q[rb+i].cyc - t0, 5 + i);
            end
        end
        n_tests++;
        if (busy_q.size() - bb !== 13 || (busy_q.size() > bb && busy_q[bb] !== t0 + 1)) begin
            n_fail++; $display("FAIL basic_busy: got %0d cycles expected 13 from start+1",
                               busy_q.size() - bb);
        end
        $display("[TB] test_basic done");
    endtask

    task automatic test_stall;
        int rb, ib, fb, db, sb, tb0, t0; bit ok;
        rb = run_q.size(); ib = ifm_q.size(); fb = filt_q.size();
        db = done_q.size(); sb = start_q.size(); tb0 = stall_q.size();
        start_layer(WS'(2), WS'(2), WC'(2), WC'(1));
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (run_q.size() - rb >= 3) break;
        end
        i_stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_stall = 1'b0;
        wait_done(db, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL stall_timeout: got no o_done expected one"); end
        t0 = (start_q.size() > sb) ? start_q[sb] : 0;
        check_basic("stall", rb, ib, fb, db, t0, 16);
        n_tests++;
        if (stall_q.size() - tb0 !== 3) begin
            n_fail++; $display("FAIL stall_cycles: got %0d expected 3", stall_q.size() - tb0);
        end
        for (int i = 0; i < 3 && tb0 + i < stall_q.size(); i++) begin
            n_tests++;
            if ({stall_q[tb0+i].run, stall_q[tb0+i].row, stall_q[tb0+i].chn, stall_q[tb0+i].col} !==
                {1'b0, WS'(0), WC'(1), WS'(1)}) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got run=%b pos=%0d/%0d/%0d expected run=0 pos=0/1/1",
                                   i, stall_q[tb0+i].run, stall_q[tb0+i].row,
                                   stall_q[tb0+i].chn, stall_q[tb0+i].col);
            end
        end
        $display("[TB] test_stall done");
    endtask

    task automatic test_multi_group;
        int rb, ib, fb, db, sb, t0, nrun, nfilt; bit ok;
        logic lc;
        rb = run_q.size(); ib = ifm_q.size(); fb = filt_q.size();
        db = done_q.size(); sb = start_q.size();
        start_layer(WS'(3), WS'(1), WC'(1), WC'(3));
        wait_done(db, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL multi_timeout: got no o_done expected one"); end
        t0 = (start_q.size() > sb) ? start_q[sb] : 0;
        n_tests++;
        if (ifm_q.size() - ib !== 1) begin
            n_fail++; $display("FAIL multi_load_ifm: got %0d expected 1", ifm_q.size() - ib);
        end
        nfilt = filt_q.size() - fb;
        n_tests++;
        if (nfilt !== 3) begin
            n_fail++; $display("FAIL multi_load_filter: got %0d expected 3", nfilt);
        end
        for (int g = 0; g < 3 && g < nfilt; g++) begin
            n_tests++;
            if ({filt_q[fb+g].outchn, filt_q[fb+g].row, filt_q[fb+g].chn, filt_q[fb+g].col} !==
                {WC'(g), WS'(0), WC'(0), WS'(0)} || filt_q[fb+g].cyc !== t0 + 3 + 5*g) begin
                n_fail++; $display("FAIL multi_filter[%0d]: got outchn=%0d cnt=%0d/%0d/%0d at %0d expected outchn=%0d cnt=0 at %0d",
                                   g, filt_q[fb+g].outchn, filt_q[fb+g].row, filt_q[fb+g].chn,
                                   filt_q[fb+g].col, filt_q[fb+g].cyc - t0, g, 3 + 5*g);
            end
        end
        nrun = run_q.size() - rb;
        n_tests++;
        if (nrun !== 9) begin
            n_fail++; $display("FAIL multi_run_count: got %0d expected 9", nrun);
        end
        for (int i = 0; i < 9 && i < nrun; i++) begin
            lc = ((i % 3) == 2);
            n_tests++;
            if ({run_q[rb+i].outchn, run_q[rb+i].row, run_q[rb+i].chn, run_q[rb+i].col} !==
                {WC'(i / 3), WS'(0), WC'(0), WS'(i % 3)}) begin
                n_fail++; $display("FAIL multi_pos[%0d]: got g=%0d pos=%0d/%0d/%0d expected g=%0d pos=0/0/%0d",
                                   i, run_q[rb+i].outchn, run_q[rb+i].row, run_q[rb+i].chn,
                                   run_q[rb+i].col, i / 3, i % 3);
            end
            n_tests++;
            if (run_q[rb+i].flags !== {4'b1111, (i % 3) == 0, lc}) begin
                n_fail++; $display("FAIL multi_flags[%0d]: got %b expected %b",
                                   i, run_q[rb+i].flags, {4'b1111, (i % 3) == 0, lc});
            end
        end
        n_tests++;
        if (done_q.size() - db !== 1 || (done_q.size() > db && done_q[db] !== t0 + 18)) begin
            n_fail++; $display("FAIL multi_done: got count=%0d expected one pulse at start+18",
                               done_q.size() - db);
        end
        $display("[TB] test_multi_group done");
    endtask

    task automatic test_zero_dim;
        int rb, ib, fb, db, sb, bb, t0; bit ok;
        rb = run_q.size(); ib = ifm_q.size(); fb = filt_q.size();
        db = done_q.size(); sb = start_q.size(); bb = busy_q.size();
        start_layer(WS'(2), WS'(2), WC'(0), WC'(1));
        wait_done(db, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL zero_timeout: got no o_done expected one"); end
        t0 = (start_q.size() > sb) ? start_q[sb] : 0;
        n_tests++;
        if (done_q.size() - db !== 1 || (done_q.size() > db && done_q[db] !== t0 + 1)) begin
            n_fail++; $display("FAIL zero_done: got count=%0d expected one pulse at start+1",
                               done_q.size() - db);
        end
        n_tests++;
        if (ifm_q.size() - ib + filt_q.size() - fb + run_q.size() - rb !== 0) begin
            n_fail++; $display("FAIL zero_activity: got ifm=%0d filt=%0d run=%0d expected 0",
                               ifm_q.size() - ib, filt_q.size() - fb, run_q.size() - rb);
        end
        n_tests++;
        if (busy_q.size() - bb !== 1 || (busy_q.size() > bb && busy_q[bb] !== t0 + 1)) begin
            n_fail++; $display("FAIL zero_busy: got %0d cycles expected 1 at start+1",
                               busy_q.size() - bb);
        end
        $display("[TB] test_zero_dim done");
    endtask

    task automatic test_ignored_events;
        int rb, ib, fb, db, sb, t0; bit ok;
        rb = run_q.size(); ib = ifm_q.size(); fb = filt_q.size();
        db = done_q.size(); sb = start_q.size();
        @(posedge clk); #1;
        q_width = WS'(2); q_height = WS'(2); q_channel = WC'(2); q_outchn_num = WC'(1);
        q_start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            case (k)
                1: q_start = 1'b0;
                3: spur_ifm = 1'b1;      // in LOAD_FILT, during the filter request
                5: spur_ifm = 1'b0;
                7: begin                 // in RUN, with a different geometry
                       q_width = WS'(3); q_height = WS'(3); q_channel = WC'(3);
                       q_outchn_num = WC'(2); q_start = 1'b1;
                   end
                8: q_start = 1'b0;
                default: ;
            endcase
        end
        wait_done(db, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL ignore_timeout: got no o_done expected one"); end
        t0 = (start_q.size() > sb) ? start_q[sb] : 0;
        check_basic("ignore", rb, ib, fb, db, t0, 13);
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (ifm_q.size() - ib !== 1 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL ignore_no_restart: got ifm=%0d busy=%b expected 1 and 0",
                               ifm_q.size() - ib, o_busy);
        end
        $display("[TB] test_ignored_events done");
    endtask

    task automatic test_reset_mid_run;
        int rb, db, ib, fb, sb, t0; bit ok;
        logic [10:0] ctl;
        rb = run_q.size(); db = done_q.size();
        start_layer(WS'(2), WS'(2), WC'(2), WC'(1));
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (run_q.size() - rb >= 5) break;
        end
        n_tests++;
        if (run_q.size() - rb < 5 || run_q[run_q.size()-1].row !== WS'(1)) begin
            n_fail++; $display("FAIL rst_reach_row1: got %0d run cycles expected row 1 reached",
                               run_q.size() - rb);
        end
        rstn = 1'b0;
        #1;
        ctl = {o_busy, o_done, o_load_ifm, o_load_filter, c_ctrl_data_run,
               c_is_first_row, c_is_last_row, c_is_first_col, c_is_last_col,
               c_is_first_chn, c_is_last_chn};
        n_tests++;
        if (ctl !== 11'd0 || {c_row, c_col, c_chn, o_outchn} !== 40'd0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got ctl=%b row=%0d col=%0d chn=%0d expected 0",
                               ctl, c_row, c_col, c_chn);
        end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (done_q.size() - db !== 0 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_no_done: got done=%0d busy=%b expected 0 and 0",
                               done_q.size() - db, o_busy);
        end
        rb = run_q.size(); ib = ifm_q.size(); fb = filt_q.size();
        db = done_q.size(); sb = start_q.size();
        start_layer(WS'(2), WS'(2), WC'(2), WC'(1));
        wait_done(db, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rst_rerun_timeout: got no o_done expected one"); end
        t0 = (start_q.size() > sb) ? start_q[sb] : 0;
        check_basic("rerun", rb, ib, fb, db, t0, 13);
        $display("[TB] test_reset_mid_run done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_multi_group();
        test_zero_dim();
        test_ignored_events();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
